// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared encodings and constants for the multiply/divide sequencer.
package muldiv_pkg;
    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;
    localparam int DIV_STEPS_DEFAULT = 32;
    localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
endpackage

// File: rtl/muldiv_div_radix2.sv
// div_radix2: unsigned radix-2 restoring divider, one quotient bit per cycle.
// done_o and quo_o/rem_o reflect the final step combinationally so the caller can load them on that edge.
module div_radix2
    import muldiv_pkg::*;
#(
    parameter int STEPS = DIV_STEPS_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic        done_o,
    output logic [31:0] quo_o,
    output logic [31:0] rem_o
);
    logic        busy_q;
    logic [5:0]  cnt_q;
    logic [31:0] rem_q, quo_q, dvs_q;
    logic [32:0] sh;
    logic        ge;
    assign sh     = {rem_q, quo_q[31]};
    assign ge     = sh >= {1'b0, dvs_q};
    assign quo_o  = {quo_q[30:0], ge};
    assign rem_o  = ge ? sh[31:0] - dvs_q : sh[31:0];
    assign done_o = busy_q && cnt_q == 6'(STEPS - 1);
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
        end else if (abort_i) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else if (start_i) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= dividend_i;
            dvs_q  <= divisor_i;
        end else if (busy_q) begin
            rem_q  <= rem_o;
            quo_q  <= quo_o;
            cnt_q  <= done_o ? '0 : cnt_q + 6'd1;
            busy_q <= !done_o;
        end
    end
endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: MULT/MULTU/DIV/DIVU sequencer holding EX via stall_o until HI/LO are ready.
// MULDIV_DIV_EARLY_OUT_EN enables the |b|>|a| divide shortcut and the div0_o flag.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int MUL_LAT   = 2,
    parameter int DIV_STEPS = DIV_STEPS_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        div0_o
);
    state_t      state_q;
    logic [2:0]  cnt_q;
    logic        neg_q, rsign_q, done_q, div0_q;
    logic [31:0] hi_q, lo_q;
    logic [63:0] prod_q [MUL_LAT];
    logic        go, is_div, sgn, b_zero, early, div_start, div_done;
    logic [31:0] abs_a, abs_b, quo, rem;
    logic [63:0] prod;
`ifdef MULDIV_DIV_EARLY_OUT_EN
    localparam bit DIV0_EN = 1'b1;
    assign early = abs_b > abs_a;
`else
    localparam bit DIV0_EN = 1'b0;
    assign early = 1'b0;
`endif
    assign go        = resetn && state_q == IDLE && start_i && !flush_i;
    assign is_div    = op_i == MD_DIV || op_i == MD_DIVU;
    assign sgn       = op_i == MD_MULT || op_i == MD_DIV;
    assign abs_a     = sgn && a_i[31] ? -a_i : a_i;
    assign abs_b     = sgn && b_i[31] ? -b_i : b_i;
    assign b_zero    = b_i == '0;
    assign div_start = go && is_div && !b_zero && !early;
    // Sign-extending to 64 bits makes one modular multiply serve both signed and unsigned ops.
    assign prod      = {{32{sgn & a_i[31]}}, a_i} * {{32{sgn & b_i[31]}}, b_i};
    assign stall_o   = go || state_q == MUL || state_q == DIV;
    assign done_o    = done_q;
    assign hi_o      = hi_q;
    assign lo_o      = lo_q;
    assign div0_o    = div0_q;
    div_radix2 #(.STEPS(DIV_STEPS)) u_div (
        .clk        (clk),
        .resetn     (resetn),
        .start_i    (div_start),
        .abort_i    (flush_i),
        .dividend_i (abs_a),
        .divisor_i  (abs_b),
        .done_o     (div_done),
        .quo_o      (quo),
        .rem_o      (rem)
    );
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            rsign_q <= 1'b0;
            done_q  <= 1'b0;
            div0_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            for (int i = 0; i < MUL_LAT; i++) prod_q[i] <= '0;
        end else begin
            done_q <= 1'b0;
            div0_q <= 1'b0;
            for (int i = 1; i < MUL_LAT; i++) prod_q[i] <= prod_q[i-1];
            if (flush_i) state_q <= IDLE;
            else case (state_q)
                IDLE: if (start_i) begin
                    cnt_q   <= '0;
                    neg_q   <= sgn & (a_i[31] ^ b_i[31]);
                    rsign_q <= sgn & a_i[31];
                    if (!is_div) begin
                        prod_q[0] <= prod;
                        state_q   <= MUL;
                    end else if (b_zero || early) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        div0_q  <= DIV0_EN && b_zero;
                        hi_q    <= a_i;
                        lo_q    <= b_zero ? DIV0_LO : '0;
                    end else state_q <= DIV;
                end
                MUL: if (cnt_q == 3'(MUL_LAT - 1)) begin
                    state_q <= DONE;
                    done_q  <= 1'b1;
                    hi_q    <= prod_q[MUL_LAT-1][63:32];
                    lo_q    <= prod_q[MUL_LAT-1][31:0];
                end else cnt_q <= cnt_q + 3'd1;
                DIV: if (div_done) begin
                    state_q <= DONE;
                    done_q  <= 1'b1;
                    hi_q    <= rsign_q ? -rem : rem;
                    lo_q    <= neg_q ? -quo : quo;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed vectors checked every cycle against an arithmetic model of the sequencer.
module tb_muldiv_ctrl;
    import muldiv_pkg::*;
    localparam int MUL_LAT = 2;
`ifdef MULDIV_DIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif
    logic        clk = 1'b0, resetn = 1'b0, start_i = 1'b0, flush_i = 1'b0;
    logic [1:0]  op_i = 2'b00;
    logic [31:0] a_i = '0, b_i = '0;
    logic        stall_o, done_o, div0_o;
    logic [31:0] hi_o, lo_o;
    logic        exp_stall = 1'b0, exp_done = 1'b0, exp_div0 = 1'b0;
    logic [31:0] exp_hi = '0, exp_lo = '0;
    int          checks = 0, fails = 0;
    always #5 clk = ~clk;
    muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .resetn(resetn), .start_i(start_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
        .flush_i(flush_i), .stall_o(stall_o), .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o), .div0_o(div0_o)
    );
    task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h want %h", n, $time, act, exp);
        end
    endtask
    always @(negedge clk) begin
        check("stall_o", 32'(stall_o), 32'(exp_stall));
        check("done_o", 32'(done_o), 32'(exp_done));
        check("div0_o", 32'(div0_o), 32'(exp_div0));
        check("hi_o", hi_o, exp_hi);
        check("lo_o", lo_o, exp_lo);
    end
    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo, output int lat, output logic d0);
        longint sa, sb, p, q, r;
        logic sgn;
        sgn = op == MD_MULT || op == MD_DIV;
        sa  = sgn ? longint'($signed(a)) : longint'({32'b0, a});
        sb  = sgn ? longint'($signed(b)) : longint'({32'b0, b});
        d0  = 1'b0;
        lat = 1 + MUL_LAT;
        if (op == MD_MULT || op == MD_MULTU) begin
            p  = sa * sb;
            hi = p[63:32];
            lo = p[31:0];
        end else if (b == 32'd0) begin
            hi  = a;
            lo  = 32'hFFFF_FFFF;
            lat = 1;
            d0  = EARLY;
        end else begin
            q   = sa / sb;
            r   = sa % sb;
            hi  = r[31:0];
            lo  = q[31:0];
            lat = (EARLY && (sb < 0 ? -sb : sb) > (sa < 0 ? -sa : sa)) ? 1 : 33;
        end
    endfunction
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] lhi, input logic [31:0] llo, input logic fl_done);
        logic [31:0] mhi, mlo;
        int          lat;
        logic        d0;
        model(op, a, b, mhi, mlo, lat, d0);
        check("model_hi", mhi, lhi);
        check("model_lo", mlo, llo);
        @(posedge clk); #1;
        start_i = 1'b1; op_i = op; a_i = a; b_i = b;
        exp_stall = 1'b1; exp_done = 1'b0;
        repeat (lat - 1) begin @(posedge clk); #1; end
        @(posedge clk); #1;
        flush_i = fl_done;
        exp_stall = 1'b0; exp_done = 1'b1; exp_div0 = d0; exp_hi = mhi; exp_lo = mlo;
        @(posedge clk); #1;
        start_i = 1'b0; flush_i = 1'b0;
        exp_done = 1'b0; exp_div0 = 1'b0;
    endtask
    initial begin
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        do_op(MD_MULT,  32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
        do_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b1);
        do_op(MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,         1'b0);
        do_op(MD_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        do_op(MD_DIVU,  32'd7,         32'd2,         32'd1,         32'd3,         1'b0);
        do_op(MD_DIV,   32'h1234,      32'd0,         32'h1234,      32'hFFFF_FFFF, 1'b0);
        do_op(MD_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b0);
        do_op(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 1'b0);
        do_op(MD_DIV,   32'd100,       32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFF2, 1'b0);
        do_op(MD_DIVU,  32'hFFFF_FFFF, 32'h10,        32'hF,         32'h0FFF_FFFF, 1'b0);
        do_op(MD_DIVU,  32'd3,         32'd10,        32'd3,         32'd0,         1'b0);
        @(posedge clk); #1;
        start_i = 1'b1; flush_i = 1'b1; op_i = MD_MULT; a_i = 32'd9; b_i = 32'd9;
        @(posedge clk); #1;
        start_i = 1'b0; flush_i = 1'b0;
        repeat (4) @(posedge clk);
        @(posedge clk); #1;
        start_i = 1'b1; op_i = MD_DIV; a_i = 32'd1000; b_i = 32'd3; exp_stall = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        flush_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0; flush_i = 1'b0; exp_stall = 1'b0;
        repeat (40) @(posedge clk);
        do_op(MD_MULT, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0);
        @(posedge clk); #1;
        start_i = 1'b1; op_i = MD_DIVU; a_i = 32'd100; b_i = 32'd7; exp_stall = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        resetn = 1'b0; exp_stall = 1'b0; exp_hi = '0; exp_lo = '0;
        @(posedge clk); #1;
        resetn = 1'b1; start_i = 1'b0;
        repeat (40) @(posedge clk);
        do_op(MD_MULTU, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, 1'b0);
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
